// File: rtl/coef_loader.sv
// Serial coefficient-bank loader: hunts for an AA 55 sync, skips ADC bytes, shadows a
// full biquad coefficient bank and commits it atomically when the XOR checksum matches.
module coef_loader #(
    parameter int unsigned   NBANDS     = 3,
    parameter int unsigned   NCOEF      = 5,
    parameter int unsigned   CW         = 16,
    parameter int unsigned   SKIP_BYTES = 10,
    parameter logic [CW-1:0] UNITY      = 16'h4000,
    parameter int unsigned   TIMEOUT    = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   rx_byte,
    input  logic                         rx_valid,
    output logic [NBANDS*NCOEF*CW-1:0]   coefs,
    output logic                         coef_update,
    output logic                         frame_err,
    output logic [7:0]                   err_count,
    output logic                         busy
);

    localparam int unsigned NWORDS  = NBANDS * NCOEF;
    localparam int unsigned TOTAL   = NWORDS * CW;
    localparam int unsigned NBYTES  = TOTAL / 8;
    localparam int unsigned CNT_MAX = (SKIP_BYTES > NBYTES) ? SKIP_BYTES : NBYTES;
    localparam int unsigned BW      = $clog2(CNT_MAX + 1);
    localparam int unsigned IW      = $clog2(TIMEOUT + 1);

    generate
        if ((CW % 8) != 0 || CW == 0) begin : g_bad_cw
            $error("coef_loader: CW must be a non-zero multiple of 8");
        end
    endgenerate

    typedef enum logic [2:0] {HUNT1, HUNT2, SKIP, COEF, CSUM} state_t;

    localparam state_t AFTER_SYNC = (SKIP_BYTES == 0) ? COEF : SKIP;

    state_t           state;
    logic [TOTAL-1:0] shadow;
    logic [7:0]       csum;
    logic [BW-1:0]    bcnt;
    logic [IW-1:0]    idle_cnt;
    logic             in_frame;
    logic             timeout_hit;

    function automatic logic [TOTAL-1:0] reset_bank();
        logic [TOTAL-1:0] b;
        b = '0;
        for (int unsigned n = 0; n < NBANDS; n++) begin
            b[(NWORDS - 1 - n * NCOEF) * CW +: CW] = UNITY;
        end
        return b;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_frame    = (state == SKIP) || (state == COEF) || (state == CSUM);
    // The abort fires on the idle edge that would bring the counter to TIMEOUT.
    assign timeout_hit = !rx_valid && in_frame && (idle_cnt >= IW'(TIMEOUT - 1));
    assign busy        = (state != HUNT1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HUNT1;
            coefs       <= reset_bank();
            shadow      <= '0;
            csum        <= '0;
            bcnt        <= '0;
            idle_cnt    <= '0;
            coef_update <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= '0;
        end else begin
            coef_update <= 1'b0;
            frame_err   <= 1'b0;

            if (rx_valid) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IW'(TIMEOUT)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (timeout_hit) begin
                state     <= HUNT1;
                frame_err <= 1'b1;
                err_count <= sat_inc(err_count);
            end else if (rx_valid) begin
                case (state)
                    HUNT1: begin
                        if (rx_byte == 8'hAA) state <= HUNT2;
                    end
                    HUNT2: begin
                        if (rx_byte == 8'h55) begin
                            state <= AFTER_SYNC;
                            csum  <= '0;
                            bcnt  <= '0;
                        end else if (rx_byte != 8'hAA) begin
                            state <= HUNT1;
                        end
                    end
                    SKIP: begin
                        csum <= csum ^ rx_byte;
                        if (bcnt == BW'(SKIP_BYTES - 1)) begin
                            state <= COEF;
                            bcnt  <= '0;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                    COEF: begin
                        csum   <= csum ^ rx_byte;
                        shadow <= (shadow << 8) | TOTAL'(rx_byte);
                        if (bcnt == BW'(NBYTES - 1)) begin
                            state <= CSUM;
                            bcnt  <= '0;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                    CSUM: begin
                        state <= HUNT1;
                        if (rx_byte == csum) begin
                            coefs       <= shadow;
                            coef_update <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            err_count <= sat_inc(err_count);
                        end
                    end
                    default: state <= HUNT1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_coef_loader.sv
// Randomized frame-level bench for coef_loader; frames are built from random words and
// the expected bank/error state is derived from whether the checksum was made correct.
module tb_coef_loader;

    localparam int unsigned NBANDS     = 3;
    localparam int unsigned NCOEF      = 5;
    localparam int unsigned CW         = 16;
    localparam int unsigned SKIP_BYTES = 10;
    localparam int unsigned TIMEOUT    = 1024;
    localparam int unsigned NWORDS     = NBANDS * NCOEF;
    localparam int unsigned TOTAL      = NWORDS * CW;
    localparam int unsigned NBYTES     = TOTAL / 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic [TOTAL-1:0] coefs;
    logic             coef_update;
    logic             frame_err;
    logic [7:0]       err_count;
    logic             busy;

    coef_loader #(
        .NBANDS(NBANDS), .NCOEF(NCOEF), .CW(CW), .SKIP_BYTES(SKIP_BYTES),
        .UNITY(16'h4000), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .coefs(coefs), .coef_update(coef_update), .frame_err(frame_err),
        .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CW-1:0]    fw [NWORDS];
    logic [TOTAL-1:0] exp_bank;
    logic [7:0]       exp_err;
    int               exp_upd  = 0;
    int               exp_ferr = 0;

    int               mon_upd  = 0;
    int               mon_ferr = 0;
    int               dbl      = 0;
    int               glitch   = 0;
    logic             prev_upd = 1'b0;
    logic             prev_ferr = 1'b0;
    logic [TOTAL-1:0] prev_coefs;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [TOTAL-1:0] pack_words();
        logic [TOTAL-1:0] b;
        b = '0;
        for (int i = 0; i < NWORDS; i++) b[(NWORDS - 1 - i) * CW +: CW] = fw[i];
        return b;
    endfunction

    function automatic logic [TOTAL-1:0] passthrough_bank();
        logic [TOTAL-1:0] b;
        b = '0;
        for (int i = 0; i < NWORDS; i++)
            b[(NWORDS - 1 - i) * CW +: CW] = (i % NCOEF == 0) ? 16'h4000 : 16'h0000;
        return b;
    endfunction

    function automatic logic [7:0] rnd_data();
        case ($urandom_range(5))
            0:       return 8'hAA;
            1:       return 8'h55;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    // partial > 0 stops after that many coefficient bytes, leaving the frame open.
    task automatic send_frame(input bit bad, input bit aa_prefix, input int gmax, input int partial);
        logic [7:0] x;
        logic [7:0] b;
        int         sent;
        x    = 8'h00;
        sent = 0;
        if (aa_prefix) send_byte(8'hAA, $urandom_range(gmax));
        send_byte(8'hAA, $urandom_range(gmax));
        send_byte(8'h55, $urandom_range(gmax));
        for (int s = 0; s < SKIP_BYTES; s++) begin
            b = rnd_data();
            x ^= b;
            send_byte(b, $urandom_range(gmax));
        end
        for (int i = 0; i < NWORDS; i++) begin
            for (int j = 0; j < CW / 8; j++) begin
                b = fw[i][(CW - 8 - 8 * j) +: 8];
                x ^= b;
                send_byte(b, $urandom_range(gmax));
                sent++;
                if (partial > 0 && sent == partial) return;
            end
        end
        send_byte(bad ? ~x : x, 0);
        if (!bad) begin
            exp_bank = pack_words();
            exp_upd++;
        end else begin
            exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
            exp_ferr++;
        end
        check("coefs_after_csum", coefs, exp_bank);
        check("coef_update", coef_update, !bad);
        check("frame_err", frame_err, bad);
        check("err_count", err_count, exp_err);
        check("busy_after_csum", busy, 1'b0);
    endtask

    task automatic random_words();
        for (int i = 0; i < NWORDS; i++) begin
            fw[i] = ($urandom_range(4) == 0) ? {8'hAA, 8'h55} : CW'($urandom);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (coef_update) mon_upd <= mon_upd + 1;
            if (frame_err) mon_ferr <= mon_ferr + 1;
            if ((coef_update && prev_upd) || (frame_err && prev_ferr)) dbl <= dbl + 1;
            if (coefs !== prev_coefs && !coef_update) glitch <= glitch + 1;
        end
        prev_upd   <= coef_update;
        prev_ferr  <= frame_err;
        prev_coefs <= coefs;
    end

    initial begin
        bit seen;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        exp_bank = passthrough_bank();
        exp_err  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_coefs", coefs, exp_bank);
        check("reset_update", coef_update, 1'b0);
        check("reset_ferr", frame_err, 1'b0);
        check("reset_errcnt", err_count, 8'h00);
        check("reset_busy", busy, 1'b0);
        @(posedge clk);
        #1;

        // Directed frame: b0 = 0x1234 in every band, all other words 0x0001
        for (int i = 0; i < NWORDS; i++) fw[i] = (i % NCOEF == 0) ? 16'h1234 : 16'h0001;
        send_frame(1'b0, 1'b0, 0, 0);
        send_frame(1'b1, 1'b0, 0, 0);

        // Extra AA before sync
        random_words();
        send_frame(1'b0, 1'b1, 1, 0);

        // Randomized traffic with junk, gaps and back-to-back frames
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(3)) begin
                logic [7:0] j;
                j = 8'($urandom);
                if (j == 8'hAA) j = 8'h00;
                send_byte(j, $urandom_range(2));
            end
            random_words();
            send_frame($urandom_range(3) == 0, $urandom_range(3) == 0, 3, 0);
            if ($urandom_range(1) == 1) begin
                repeat ($urandom_range(4) + 1) @(posedge clk);
                #1;
            end
        end

        // Stall mid-COEF until the idle timeout aborts the frame
        random_words();
        send_frame(1'b0, 1'b0, 0, NBYTES / 2);
        repeat (TIMEOUT - 2) @(negedge clk);
        check("busy_before_timeout", busy, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (frame_err) seen = 1'b1;
        end
        exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
        exp_ferr++;
        check("timeout_err_seen", seen, 1'b1);
        check("timeout_busy", busy, 1'b0);
        check("timeout_coefs", coefs, exp_bank);
        check("timeout_errcnt", err_count, exp_err);
        @(posedge clk);
        #1;
        random_words();
        send_frame(1'b0, 1'b0, 1, 0);

        // Enough bad frames to saturate err_count
        for (int f = 0; f < 300; f++) begin
            random_words();
            send_frame(1'b1, 1'b0, 0, 0);
        end
        check("errcnt_saturated", err_count, 8'hFF);

        // Reset in the middle of the 301st frame
        random_words();
        send_frame(1'b0, 1'b0, 0, 5);
        #2 reset = 1'b1;
        #1;
        exp_bank = passthrough_bank();
        exp_err  = 8'h00;
        check("midreset_coefs", coefs, exp_bank);
        check("midreset_errcnt", err_count, 8'h00);
        check("midreset_busy", busy, 1'b0);
        check("midreset_flags", {coef_update, frame_err}, 2'b00);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        random_words();
        send_frame(1'b0, 1'b0, 2, 0);

        repeat (2) @(posedge clk);
        #1;
        check("update_pulse_count", mon_upd, exp_upd);
        check("ferr_pulse_count", mon_ferr, exp_ferr);
        check("pulse_width", dbl, 0);
        check("coefs_changed_without_commit", glitch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
